// File: rtl/rob_free_list_pkg.sv
// Shared sizing, index types and modular index arithmetic for the physical-register free list.
`ifndef PHYS_REG_SZ_R10K
`define PHYS_REG_SZ_R10K 64
`endif
`ifndef N
`define N 3
`endif

package rob_free_list_pkg;
  localparam int DEPTH        = `PHYS_REG_SZ_R10K;
  localparam int N            = `N;
  localparam int ARCH_REGS    = 32;
  localparam int FL_SIZE      = DEPTH - ARCH_REGS;
  localparam int PHYS_REG_IDX = $clog2(DEPTH);
  localparam int IDX_W        = (FL_SIZE > 1) ? $clog2(FL_SIZE) : 1;
  localparam int CNT_W        = $clog2(N + 1);
  localparam int AVAIL_W      = $clog2(FL_SIZE + 1);

  typedef logic [PHYS_REG_IDX-1:0] tag_t;
  typedef logic [IDX_W-1:0]        fl_idx_t;

  // (idx + inc) mod FL_SIZE; valid for inc < FL_SIZE, so one subtract suffices.
  function automatic fl_idx_t wrap_add(input fl_idx_t idx, input logic [AVAIL_W-1:0] inc);
    logic [AVAIL_W:0] sum;
    sum = (AVAIL_W+1)'(idx) + (AVAIL_W+1)'(inc);
    if (sum >= (AVAIL_W+1)'(FL_SIZE)) sum = sum - (AVAIL_W+1)'(FL_SIZE);
    return sum[IDX_W-1:0];
  endfunction
endpackage

// File: rtl/rob_free_list_if.sv
// Retire-push / dispatch-pop bundle of the free list; master is the core side, slave the free list.
interface rob_free_list_if;
  import rob_free_list_pkg::*;

  tag_t [N-1:0]        wr_reg;
  logic [CNT_W-1:0]    wr_num;
  logic [CNT_W-1:0]    rd_num;
  tag_t [N-1:0]        rd_reg;
  logic [AVAIL_W-1:0]  num_avail;
  logic                rd_err;
`ifdef FREE_LIST_CHECKPOINT_EN
  logic                ckpt_save;
  logic                ckpt_restore;
`endif

  modport master (
`ifdef FREE_LIST_CHECKPOINT_EN
    output ckpt_save, ckpt_restore,
`endif
    output wr_reg, wr_num, rd_num,
    input  rd_reg, num_avail, rd_err
  );

  modport slave (
`ifdef FREE_LIST_CHECKPOINT_EN
    input  ckpt_save, ckpt_restore,
`endif
    input  wr_reg, wr_num, rd_num,
    output rd_reg, num_avail, rd_err
  );
endinterface

// File: rtl/rob_free_list_compact.sv
// Drops invalid and zero (no-destination) retire lanes and packs the survivors toward lane 0.
module fl_compact #(
  parameter int N  = 3,
  parameter int P  = 6,
  parameter int CW = $clog2(N + 1)
) (
  input  logic [N-1:0][P-1:0] wr_reg,
  input  logic [CW-1:0]       wr_num,
  output logic [N-1:0][P-1:0] packed_reg,
  output logic [CW-1:0]       pushes
);
  logic [N-1:0] lane_vld;

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign lane_vld[i] = (CW'(i) < wr_num) && (wr_reg[i] != '0);
  end

  // Running count of kept lanes doubles as the write slot, preserving lane order.
  always_comb begin
    packed_reg = '0;
    pushes     = '0;
    for (int i = 0; i < N; i++) begin
      if (lane_vld[i]) begin
        packed_reg[pushes] = wr_reg[i];
        pushes             = pushes + CW'(1);
      end
    end
  end
endmodule

// File: rtl/rob_free_list.sv
// Circular physical-tag free list, N-wide push/pop per cycle.
// Optional FREE_LIST_CHECKPOINT_EN adds head checkpoint save/restore for mispredict recovery.
module rob_free_list
  import rob_free_list_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  rob_free_list_if.slave fl
);
  tag_t               entries [FL_SIZE];
  fl_idx_t            head, tail, head_next, tail_next;
  logic [AVAIL_W-1:0] count, count_next;
  logic               rd_err_q;

  tag_t [N-1:0]       packed_reg;
  logic [CNT_W-1:0]   pushes;
  logic [AVAIL_W-1:0] rd_req, pops, pops_eff, ret, pushes_eff;
  logic [AVAIL_W:0]   used, cap, push_ext;
  logic               pop_err, restore;

  fl_compact #(.N(N), .P(PHYS_REG_IDX), .CW(CNT_W)) u_compact (
    .wr_reg     (fl.wr_reg),
    .wr_num     (fl.wr_num),
    .packed_reg (packed_reg),
    .pushes     (pushes)
  );

`ifdef FREE_LIST_CHECKPOINT_EN
  fl_idx_t            ckpt_head;
  logic [AVAIL_W-1:0] popped_since_ckpt;
  assign restore = fl.ckpt_restore;
  assign ret     = restore ? popped_since_ckpt : '0;
`else
  assign restore = 1'b0;
  assign ret     = '0;
`endif

  always_comb begin
    rd_req   = AVAIL_W'(fl.rd_num);
    pop_err  = rd_req > count;
    pops     = pop_err ? count : rd_req;
    pops_eff = restore ? '0 : pops;
    // Occupancy after pops (or after restore returns the speculatively popped tags).
    used     = (AVAIL_W+1)'(count) + (AVAIL_W+1)'(ret) - (AVAIL_W+1)'(pops_eff);
    cap      = (used >= (AVAIL_W+1)'(FL_SIZE)) ? '0 : (AVAIL_W+1)'(FL_SIZE) - used;
    push_ext = (AVAIL_W+1)'(pushes);
    pushes_eff = (push_ext > cap) ? cap[AVAIL_W-1:0] : push_ext[AVAIL_W-1:0];
    count_next = used[AVAIL_W-1:0] + pushes_eff;
    tail_next  = wrap_add(tail, pushes_eff);
    head_next  = wrap_add(head, pops_eff);
`ifdef FREE_LIST_CHECKPOINT_EN
    if (restore) head_next = ckpt_head;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < FL_SIZE; i++) entries[i] <= tag_t'(ARCH_REGS + i);
      head     <= '0;
      tail     <= '0;
      count    <= AVAIL_W'(FL_SIZE);
      rd_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++)
        if (AVAIL_W'(i) < pushes_eff) entries[wrap_add(tail, AVAIL_W'(i))] <= packed_reg[i];
      head     <= head_next;
      tail     <= tail_next;
      count    <= count_next;
      rd_err_q <= pop_err && !restore;
    end
  end

`ifdef FREE_LIST_CHECKPOINT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      ckpt_head         <= '0;
      popped_since_ckpt <= '0;
    end else if (restore) begin
      popped_since_ckpt <= '0;
    end else if (fl.ckpt_save) begin
      ckpt_head         <= head_next;
      popped_since_ckpt <= '0;
    end else begin
      popped_since_ckpt <= popped_since_ckpt + pops_eff;
    end
  end
`endif

  always_comb begin
    fl.rd_reg = '0;
    for (int i = 0; i < N; i++) fl.rd_reg[i] = entries[wrap_add(head, AVAIL_W'(i))];
  end

  assign fl.num_avail = count;
  assign fl.rd_err    = rd_err_q;

`ifndef SYNTHESIS
  always_ff @(posedge clock)
    if (!reset) assert (push_ext <= cap) else $error("free list overflow: excess tags dropped");
`endif
endmodule

// File: tb/tb_rob_free_list.sv
// Directed bench for rob_free_list at DEPTH=64, N=3, ARCH_REGS=32 (FL_SIZE=32).
module tb_rob_free_list;
  import rob_free_list_pkg::*;

  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;

  rob_free_list_if fl_if ();
  rob_free_list dut (.clock(clock), .reset(reset), .fl(fl_if));

  task automatic idle_inputs();
    fl_if.rd_num = '0;
    fl_if.wr_num = '0;
    fl_if.wr_reg = '0;
`ifdef FREE_LIST_CHECKPOINT_EN
    fl_if.ckpt_save    = 1'b0;
    fl_if.ckpt_restore = 1'b0;
`endif
  endtask

  // One clock with the given pop request and retire lanes; outputs settle #1 after the edge.
  task automatic cyc(input int rd, input int wn, input int t0, input int t1, input int t2);
    fl_if.rd_num    = CNT_W'(rd);
    fl_if.wr_num    = CNT_W'(wn);
    fl_if.wr_reg[0] = tag_t'(t0);
    fl_if.wr_reg[1] = tag_t'(t1);
    fl_if.wr_reg[2] = tag_t'(t2);
    @(posedge clock); #1;
    idle_inputs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    total++; if (fl_if.num_avail !== 6'd32) begin bad++; $display("FAIL reset_avail got=%0d exp=32", fl_if.num_avail); end
    total++; if (fl_if.rd_reg[0] !== 6'd32) begin bad++; $display("FAIL reset_rd0 got=%0d exp=32", fl_if.rd_reg[0]); end
    total++; if (fl_if.rd_reg[1] !== 6'd33) begin bad++; $display("FAIL reset_rd1 got=%0d exp=33", fl_if.rd_reg[1]); end
    total++; if (fl_if.rd_reg[2] !== 6'd34) begin bad++; $display("FAIL reset_rd2 got=%0d exp=34", fl_if.rd_reg[2]); end
    total++; if (fl_if.rd_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b exp=0", fl_if.rd_err); end
  endtask

  task automatic test_pop();
    cyc(3, 0, 0, 0, 0);
    total++; if (fl_if.num_avail !== 6'd29) begin bad++; $display("FAIL pop_avail got=%0d exp=29", fl_if.num_avail); end
    total++; if (fl_if.rd_reg[0] !== 6'd35) begin bad++; $display("FAIL pop_rd0 got=%0d exp=35", fl_if.rd_reg[0]); end
    total++; if (fl_if.rd_reg[1] !== 6'd36) begin bad++; $display("FAIL pop_rd1 got=%0d exp=36", fl_if.rd_reg[1]); end
    total++; if (fl_if.rd_reg[2] !== 6'd37) begin bad++; $display("FAIL pop_rd2 got=%0d exp=37", fl_if.rd_reg[2]); end
  endtask

  task automatic test_underflow();
    for (int i = 0; i < 9; i++) cyc(3, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    total++; if (fl_if.num_avail !== 6'd1) begin bad++; $display("FAIL uflow_pre_avail got=%0d exp=1", fl_if.num_avail); end
    total++; if (fl_if.rd_reg[0] !== 6'd63) begin bad++; $display("FAIL uflow_last_tag got=%0d exp=63", fl_if.rd_reg[0]); end
    cyc(3, 0, 0, 0, 0);
    total++; if (fl_if.num_avail !== 6'd0) begin bad++; $display("FAIL uflow_avail got=%0d exp=0", fl_if.num_avail); end
    total++; if (fl_if.rd_err !== 1'b1) begin bad++; $display("FAIL uflow_err got=%0b exp=1", fl_if.rd_err); end
    cyc(0, 0, 0, 0, 0);
    total++; if (fl_if.rd_err !== 1'b0) begin bad++; $display("FAIL uflow_err_clear got=%0b exp=0", fl_if.rd_err); end
    total++; if (fl_if.num_avail !== 6'd0) begin bad++; $display("FAIL uflow_empty got=%0d exp=0", fl_if.num_avail); end
  endtask

  // Starts empty with head = tail = 0.
  task automatic test_push_filter();
    cyc(0, 3, 5, 0, 9);
    total++; if (fl_if.num_avail !== 6'd2) begin bad++; $display("FAIL filt_avail got=%0d exp=2", fl_if.num_avail); end
    total++; if (fl_if.rd_reg[0] !== 6'd5) begin bad++; $display("FAIL filt_rd0 got=%0d exp=5", fl_if.rd_reg[0]); end
    total++; if (fl_if.rd_reg[1] !== 6'd9) begin bad++; $display("FAIL filt_rd1 got=%0d exp=9", fl_if.rd_reg[1]); end
    // Lane 2 lies beyond wr_num and must be ignored.
    cyc(2, 2, 11, 12, 13);
    total++; if (fl_if.num_avail !== 6'd2) begin bad++; $display("FAIL wrnum_avail got=%0d exp=2", fl_if.num_avail); end
    total++; if (fl_if.rd_reg[0] !== 6'd11) begin bad++; $display("FAIL wrnum_rd0 got=%0d exp=11", fl_if.rd_reg[0]); end
    total++; if (fl_if.rd_reg[1] !== 6'd12) begin bad++; $display("FAIL wrnum_rd1 got=%0d exp=12", fl_if.rd_reg[1]); end
    cyc(2, 0, 0, 0, 0);
    // Pop on empty while pushing: no bypass, so nothing popped and the error flags.
    cyc(3, 3, 20, 21, 22);
    total++; if (fl_if.num_avail !== 6'd3) begin bad++; $display("FAIL nobyp_avail got=%0d exp=3", fl_if.num_avail); end
    total++; if (fl_if.rd_err !== 1'b1) begin bad++; $display("FAIL nobyp_err got=%0b exp=1", fl_if.rd_err); end
    total++; if (fl_if.rd_reg[0] !== 6'd20) begin bad++; $display("FAIL nobyp_rd0 got=%0d exp=20", fl_if.rd_reg[0]); end
    total++; if (fl_if.rd_reg[2] !== 6'd22) begin bad++; $display("FAIL nobyp_rd2 got=%0d exp=22", fl_if.rd_reg[2]); end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    cyc(3, 3, 1, 2, 3);
    reset = 1'b0;
    total++; if (fl_if.num_avail !== 6'd32) begin bad++; $display("FAIL rmid_avail got=%0d exp=32", fl_if.num_avail); end
    total++; if (fl_if.rd_reg[0] !== 6'd32) begin bad++; $display("FAIL rmid_rd0 got=%0d exp=32", fl_if.rd_reg[0]); end
    total++; if (fl_if.rd_err !== 1'b0) begin bad++; $display("FAIL rmid_err got=%0b exp=0", fl_if.rd_err); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 10; i++) cyc(3, 0, 0, 0, 0);
    total++; if (fl_if.rd_reg[0] !== 6'd62) begin bad++; $display("FAIL wrap_h30_rd0 got=%0d exp=62", fl_if.rd_reg[0]); end
    cyc(0, 3, 1, 2, 3);
    cyc(0, 3, 4, 5, 6);
    cyc(0, 3, 7, 0, 8);
    total++; if (fl_if.num_avail !== 6'd10) begin bad++; $display("FAIL wrap_fill_avail got=%0d exp=10", fl_if.num_avail); end
    total++; if (fl_if.rd_reg[1] !== 6'd63) begin bad++; $display("FAIL wrap_rd1 got=%0d exp=63", fl_if.rd_reg[1]); end
    total++; if (fl_if.rd_reg[2] !== 6'd1) begin bad++; $display("FAIL wrap_rd2 got=%0d exp=1", fl_if.rd_reg[2]); end
    cyc(3, 3, 40, 41, 42);
    total++; if (fl_if.num_avail !== 6'd10) begin bad++; $display("FAIL steady_avail got=%0d exp=10", fl_if.num_avail); end
    total++; if (fl_if.rd_reg[0] !== 6'd2) begin bad++; $display("FAIL steady_rd0 got=%0d exp=2", fl_if.rd_reg[0]); end
    total++; if (fl_if.rd_reg[2] !== 6'd4) begin bad++; $display("FAIL steady_rd2 got=%0d exp=4", fl_if.rd_reg[2]); end
    cyc(3, 0, 0, 0, 0);
    cyc(3, 0, 0, 0, 0);
    total++; if (fl_if.rd_reg[0] !== 6'd8) begin bad++; $display("FAIL drain_rd0 got=%0d exp=8", fl_if.rd_reg[0]); end
    total++; if (fl_if.rd_reg[1] !== 6'd40) begin bad++; $display("FAIL drain_rd1 got=%0d exp=40", fl_if.rd_reg[1]); end
    cyc(1, 0, 0, 0, 0);
    total++; if (fl_if.num_avail !== 6'd3) begin bad++; $display("FAIL drain_avail got=%0d exp=3", fl_if.num_avail); end
    total++; if (fl_if.rd_reg[0] !== 6'd40) begin bad++; $display("FAIL drain2_rd0 got=%0d exp=40", fl_if.rd_reg[0]); end
    total++; if (fl_if.rd_reg[2] !== 6'd42) begin bad++; $display("FAIL drain2_rd2 got=%0d exp=42", fl_if.rd_reg[2]); end
    cyc(3, 0, 0, 0, 0);
    total++; if (fl_if.num_avail !== 6'd0) begin bad++; $display("FAIL drain_empty got=%0d exp=0", fl_if.num_avail); end
    total++; if (fl_if.rd_err !== 1'b0) begin bad++; $display("FAIL drain_err got=%0b exp=0", fl_if.rd_err); end
  endtask

`ifdef FREE_LIST_CHECKPOINT_EN
  task automatic test_ckpt();
    do_reset();
    cyc(3, 0, 0, 0, 0);
    fl_if.ckpt_save = 1'b1;
    cyc(0, 0, 0, 0, 0);
    cyc(3, 0, 0, 0, 0);
    cyc(3, 0, 0, 0, 0);
    total++; if (fl_if.num_avail !== 6'd23) begin bad++; $display("FAIL ckpt_spec_avail got=%0d exp=23", fl_if.num_avail); end
    total++; if (fl_if.rd_reg[0] !== 6'd41) begin bad++; $display("FAIL ckpt_spec_rd0 got=%0d exp=41", fl_if.rd_reg[0]); end
    // Pop request during restore must be ignored; the push still lands.
    fl_if.ckpt_restore = 1'b1;
    cyc(3, 1, 7, 0, 0);
    total++; if (fl_if.num_avail !== 6'd30) begin bad++; $display("FAIL ckpt_rest_avail got=%0d exp=30", fl_if.num_avail); end
    total++; if (fl_if.rd_reg[0] !== 6'd35) begin bad++; $display("FAIL ckpt_rest_rd0 got=%0d exp=35", fl_if.rd_reg[0]); end
  endtask
`endif

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_pop();
    test_underflow();
    test_push_filter();
    test_reset_mid();
    test_wrap();
`ifdef FREE_LIST_CHECKPOINT_EN
    test_ckpt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
